// File: rtl/kb_pkg.sv
// Shared types and constants for the keyboard command sequencer.
package kb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_LATCH,
    ST_CHECK
  } kb_state_e;

  localparam logic [7:0] KC_BREAK = 8'hF0;
  localparam logic [7:0] KC_EXT   = 8'hE0;

endpackage

// File: rtl/kb_cmd_fifo.sv
// Small synchronous circular-buffer FIFO. Push while full is accepted
// when a pop happens in the same cycle, since the pop frees the slot.
module kb_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         Clk_V,
  input  logic         Reset_V,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer advance and storage write; storage is cleared so the head reads 0 after reset
  always_ff @(posedge Clk_V or posedge Reset_V) begin
    if (Reset_V) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/kb_cmd_sequencer.sv
// PS/2 scan-code sequencer: filters prefixes and repeats, holds each make
// code on the external validator, and queues accepted ASCII commands.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for a scan byte
//   ST_BRK   | F0 seen; next byte is a released key
//   ST_EXT   | E0 seen; next byte is an extended key (dropped)
//   ST_LATCH | code_r on validator input, validator enable settling
//   ST_CHECK | validator result sampled; push / drop / count reject
module kb_cmd_sequencer
  import kb_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 8
) (
  input  logic             Clk_V,
  input  logic             Reset_V,
  input  logic [7:0]       rx_byte_i,
  input  logic             rx_done_i,
  output logic [7:0]       val_keycode_o,
  input  logic [7:0]       val_ascii_i,
  input  logic             val_invalid_i,
  output logic [7:0]       cmd_data_o,
  output logic             cmd_valid_o,
  input  logic             cmd_ready_i,
  output logic             fifo_full_o,
  output logic             err_invalid_o,
  output logic             drop_o,
  output logic [CNT_W-1:0] invalid_cnt_o
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  kb_state_e        state;
  logic [7:0]       code_r;
  logic [7:0]       last_make;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] invalid_cnt;
  logic             err_r;
  logic             drop_r;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             fifo_push;
  logic [7:0]       fifo_head;

  // A pop in the CHECK cycle makes room, so a full FIFO still accepts the push
  assign fifo_pop  = cmd_ready_i & ~fifo_empty;
  assign fifo_push = (state == ST_CHECK) & ~val_invalid_i & (~fifo_full | fifo_pop);

  kb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .Clk_V     (Clk_V),
    .Reset_V   (Reset_V),
    .push      (fifo_push),
    .push_data (val_ascii_i),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sequencing FSM with prefix timeout, reject counter and registered pulses
  always_ff @(posedge Clk_V or posedge Reset_V) begin
    if (Reset_V) begin
      state       <= ST_IDLE;
      code_r      <= 8'h00;
      last_make   <= 8'h00;
      timer       <= '0;
      invalid_cnt <= '0;
      err_r       <= 1'b0;
      drop_r      <= 1'b0;
    end else begin
      err_r  <= 1'b0;
      drop_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_done_i) begin
            if (rx_byte_i == KC_BREAK) begin
              state <= ST_BRK;
              timer <= TLOAD;
            end else if (rx_byte_i == KC_EXT) begin
              state <= ST_EXT;
              timer <= TLOAD;
            end else if (rx_byte_i != last_make) begin
              code_r    <= rx_byte_i;
              last_make <= rx_byte_i;
              state     <= ST_LATCH;
            end
          end
        end
        ST_BRK: begin
          if (rx_done_i) begin
            if (rx_byte_i == last_make) last_make <= 8'h00;
            state <= ST_IDLE;
            timer <= '0;
          end else if (timer == '0) begin
            state <= ST_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_done_i) begin
            if (rx_byte_i == KC_BREAK) begin
              state <= ST_BRK;
              timer <= TLOAD;
            end else begin
              state <= ST_IDLE;
              timer <= '0;
            end
          end else if (timer == '0) begin
            state <= ST_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_LATCH: begin
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (val_invalid_i) begin
            err_r <= 1'b1;
            if (invalid_cnt != CNT_MAX) invalid_cnt <= invalid_cnt + 1'b1;
          end else if (fifo_full & ~fifo_pop) begin
            drop_r <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign val_keycode_o = code_r;
  assign cmd_data_o    = fifo_head;
  assign cmd_valid_o   = ~fifo_empty;
  assign fifo_full_o   = fifo_full;
  assign err_invalid_o = err_r;
  assign drop_o        = drop_r;
  assign invalid_cnt_o = invalid_cnt;

endmodule

// File: tb/tb_kb_cmd_sequencer.sv
// Bench for kb_cmd_sequencer: vector table, corner-case sequences and a
// randomized run against a byte-stream reference model.
module tb_kb_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 1024;
  localparam int CW    = 8;

  logic          Clk_V = 1'b0;
  logic          Reset_V;
  logic [7:0]    rx_byte_i;
  logic          rx_done_i;
  logic [7:0]    val_keycode_o;
  logic [7:0]    val_ascii_i;
  logic          val_invalid_i;
  logic [7:0]    cmd_data_o;
  logic          cmd_valid_o;
  logic          cmd_ready_i;
  logic          fifo_full_o;
  logic          err_invalid_o;
  logic          drop_o;
  logic [CW-1:0] invalid_cnt_o;

  int errors = 0;
  int checks = 0;
  int err_seen = 0;
  int drop_seen = 0;

  kb_cmd_sequencer #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO),
    .CNT_W       (CW)
  ) dut (
    .Clk_V         (Clk_V),
    .Reset_V       (Reset_V),
    .rx_byte_i     (rx_byte_i),
    .rx_done_i     (rx_done_i),
    .val_keycode_o (val_keycode_o),
    .val_ascii_i   (val_ascii_i),
    .val_invalid_i (val_invalid_i),
    .cmd_data_o    (cmd_data_o),
    .cmd_valid_o   (cmd_valid_o),
    .cmd_ready_i   (cmd_ready_i),
    .fifo_full_o   (fifo_full_o),
    .err_invalid_o (err_invalid_o),
    .drop_o        (drop_o),
    .invalid_cnt_o (invalid_cnt_o)
  );

  always #5 Clk_V = ~Clk_V;

  // Validator lookup: {invalid, ascii}
  function automatic logic [8:0] vlookup(input logic [7:0] k);
    case (k)
      8'h16: return {1'b0, 8'h31};
      8'h1E: return {1'b0, 8'h32};
      8'h26: return {1'b0, 8'h33};
      8'h25: return {1'b0, 8'h34};
      8'h2E: return {1'b0, 8'h35};
      8'h1C: return {1'b0, 8'h61};
      8'h32: return {1'b0, 8'h62};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  // Registered validator beside the sequencer
  always @(posedge Clk_V or posedge Reset_V) begin
    if (Reset_V) {val_invalid_i, val_ascii_i} <= 9'h000;
    else         {val_invalid_i, val_ascii_i} <= vlookup(val_keycode_o);
  end

  // Pulse counters
  always @(posedge Clk_V) begin
    if (err_invalid_o) err_seen <= err_seen + 1;
    if (drop_o)        drop_seen <= drop_seen + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    Reset_V = 1'b1;
    rx_done_i = 1'b0;
    rx_byte_i = 8'h00;
    cmd_ready_i = 1'b0;
    repeat (2) @(posedge Clk_V);
    #1 Reset_V = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte_i = b;
    rx_done_i = 1'b1;
    @(posedge Clk_V);
    #1 rx_done_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk_V);
    #1;
  endtask

  task automatic pop_one();
    cmd_ready_i = 1'b1;
    @(posedge Clk_V);
    #1 cmd_ready_i = 1'b0;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       push;
    logic [7:0] ascii;
    logic       inv;
  } vec_t;

  vec_t tbl[22];
  logic [7:0] full_keys[5];
  logic [7:0] drain_exp[4];
  logic [7:0] pool[12];

  // reference-model state for the random run
  logic [7:0] q[$];
  logic [7:0] m_last;
  int         m_mode;
  logic [7:0] m_cnt;
  logic       m_pend;
  logic [7:0] m_code;
  int         m_due;
  int         cyc;
  logic       exp_err, exp_drop;
  int         gap;
  int         lat, e0, d0;

  initial begin
    tbl[0]  = '{8'h16, 1'b1, 8'h31, 1'b0};
    tbl[1]  = '{8'hF0, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{8'h16, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{8'h16, 1'b1, 8'h31, 1'b0};
    tbl[4]  = '{8'h16, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{8'h16, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{8'hF0, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{8'h16, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{8'h16, 1'b1, 8'h31, 1'b0};
    tbl[9]  = '{8'h1A, 1'b0, 8'h00, 1'b1};
    tbl[10] = '{8'hE0, 1'b0, 8'h00, 1'b0};
    tbl[11] = '{8'h1E, 1'b0, 8'h00, 1'b0};
    tbl[12] = '{8'h1E, 1'b1, 8'h32, 1'b0};
    tbl[13] = '{8'hE0, 1'b0, 8'h00, 1'b0};
    tbl[14] = '{8'hF0, 1'b0, 8'h00, 1'b0};
    tbl[15] = '{8'h1E, 1'b0, 8'h00, 1'b0};
    tbl[16] = '{8'h1E, 1'b1, 8'h32, 1'b0};
    tbl[17] = '{8'h1A, 1'b0, 8'h00, 1'b1};
    tbl[18] = '{8'h1A, 1'b0, 8'h00, 1'b0};
    tbl[19] = '{8'h32, 1'b1, 8'h62, 1'b0};
    tbl[20] = '{8'hE0, 1'b0, 8'h00, 1'b0};
    tbl[21] = '{8'h2E, 1'b0, 8'h00, 1'b0};
    full_keys = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    drain_exp = '{8'h32, 8'h33, 8'h34, 8'h61};
    pool = '{8'hF0, 8'hE0, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h1C, 8'h32, 8'h1A, 8'h1B, 8'h00};

    // reset state
    Reset_V = 1'b1;
    rx_done_i = 1'b0;
    rx_byte_i = 8'h00;
    cmd_ready_i = 1'b0;
    #3;
    chk("rst_valid", cmd_valid_o, 0);
    chk("rst_data", cmd_data_o, 0);
    chk("rst_full", fifo_full_o, 0);
    chk("rst_err", err_invalid_o, 0);
    chk("rst_drop", drop_o, 0);
    chk("rst_cnt", invalid_cnt_o, 0);
    chk("rst_keycode", val_keycode_o, 0);
    do_reset();

    // latency: strobe to cmd_valid_o
    send_byte(8'h16);
    lat = 1;
    while (!cmd_valid_o && lat < 10) begin
      @(posedge Clk_V); #1;
      lat++;
    end
    chk("latency", lat, 3);
    chk("latency_data", cmd_data_o, 8'h31);
    pop_one();

    // vector table
    do_reset();
    for (int i = 0; i < 22; i++) begin
      e0 = err_seen;
      send_byte(tbl[i].b);
      idle(4);
      @(negedge Clk_V);
      chk($sformatf("tbl%0d_valid", i), cmd_valid_o, tbl[i].push);
      if (tbl[i].push) chk($sformatf("tbl%0d_data", i), cmd_data_o, tbl[i].ascii);
      chk($sformatf("tbl%0d_err", i), err_seen - e0, tbl[i].inv);
      if (cmd_valid_o) pop_one();
    end
    @(negedge Clk_V);
    chk("tbl_cnt", invalid_cnt_o, 2);

    // invalid counter saturation
    do_reset();
    e0 = err_seen;
    send_byte(8'h1A);
    idle(4);
    @(negedge Clk_V);
    chk("sat_cnt1", invalid_cnt_o, 1);
    chk("sat_err1", err_seen - e0, 1);
    for (int i = 0; i < 256; i++) begin
      send_byte((i % 2 == 0) ? 8'h1B : 8'h1A);
      idle(3);
    end
    idle(2);
    @(negedge Clk_V);
    chk("sat_cnt", invalid_cnt_o, 8'hFF);
    chk("sat_err", err_seen - e0, 257);
    chk("sat_nopush", cmd_valid_o, 0);

    // full FIFO, drop, push+pop at full, drain
    do_reset();
    d0 = drop_seen;
    for (int i = 0; i < 5; i++) begin
      send_byte(full_keys[i]);
      idle(4);
    end
    @(negedge Clk_V);
    chk("full_flag", fifo_full_o, 1);
    chk("full_drop", drop_seen - d0, 1);
    chk("full_head", cmd_data_o, 8'h31);
    send_byte(8'h1C);
    @(posedge Clk_V); #1;
    cmd_ready_i = 1'b1;
    @(posedge Clk_V); #1;
    cmd_ready_i = 1'b0;
    idle(2);
    @(negedge Clk_V);
    chk("pp_full", fifo_full_o, 1);
    chk("pp_drop", drop_seen - d0, 1);
    chk("pp_head", cmd_data_o, 8'h32);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk_V);
      chk($sformatf("drain%0d_valid", i), cmd_valid_o, 1);
      chk($sformatf("drain%0d_data", i), cmd_data_o, drain_exp[i]);
      cmd_ready_i = 1'b1;
      @(posedge Clk_V); #1;
      cmd_ready_i = 1'b0;
    end
    @(negedge Clk_V);
    chk("drain_empty", cmd_valid_o, 0);
    chk("drain_notfull", fifo_full_o, 0);

    // prefix timeout boundary
    do_reset();
    send_byte(8'h1E);
    idle(4);
    @(negedge Clk_V);
    chk("tmo_pre", cmd_data_o, 8'h32);
    pop_one();
    send_byte(8'hF0);
    idle(TMO - 1);
    send_byte(8'h16);
    idle(4);
    @(negedge Clk_V);
    chk("tmo_edge_still_brk", cmd_valid_o, 0);
    send_byte(8'hF0);
    idle(TMO);
    send_byte(8'h26);
    idle(4);
    @(negedge Clk_V);
    chk("tmo_brk_valid", cmd_valid_o, 1);
    chk("tmo_brk_data", cmd_data_o, 8'h33);
    pop_one();
    send_byte(8'hE0);
    idle(TMO);
    send_byte(8'h1E);
    idle(4);
    @(negedge Clk_V);
    chk("tmo_ext_valid", cmd_valid_o, 1);
    chk("tmo_ext_data", cmd_data_o, 8'h32);
    pop_one();

    // reset in the CHECK cycle while full and popping
    do_reset();
    e0 = err_seen;
    d0 = drop_seen;
    for (int i = 0; i < 4; i++) begin
      send_byte(full_keys[i]);
      idle(4);
    end
    chk("rstm_full_before", fifo_full_o, 1);
    send_byte(8'h2E);
    @(posedge Clk_V); #1;
    cmd_ready_i = 1'b1;
    #2 Reset_V = 1'b1;
    #1;
    chk("rstm_valid", cmd_valid_o, 0);
    chk("rstm_full", fifo_full_o, 0);
    chk("rstm_data", cmd_data_o, 0);
    chk("rstm_cnt", invalid_cnt_o, 0);
    chk("rstm_keycode", val_keycode_o, 0);
    chk("rstm_err", err_invalid_o, 0);
    chk("rstm_drop", drop_o, 0);
    @(posedge Clk_V); #1;
    Reset_V = 1'b0;
    cmd_ready_i = 1'b0;
    idle(5);
    @(negedge Clk_V);
    chk("rstm_after_valid", cmd_valid_o, 0);
    chk("rstm_after_drop", drop_seen - d0, 0);
    chk("rstm_after_err", err_seen - e0, 0);

    // randomized run against the byte-stream model
    do_reset();
    q.delete();
    m_last = 8'h00; m_mode = 0; m_cnt = 8'h00; m_pend = 1'b0;
    m_code = 8'h00; m_due = 0; cyc = 0;
    exp_err = 1'b0; exp_drop = 1'b0; gap = 2;
    for (int c = 0; c < 6000; c++) begin
      logic       pop, push_ok;
      logic [8:0] r;
      logic [7:0] b;
      if (gap == 0) begin
        int idx;
        idx = $urandom_range(0, 12);
        rx_byte_i = (idx == 12) ? 8'($urandom_range(0, 255)) : pool[idx];
        rx_done_i = 1'b1;
        gap = $urandom_range(4, 12);
      end else begin
        rx_done_i = 1'b0;
        gap--;
      end
      cmd_ready_i = ($urandom_range(0, 3) == 0);
      @(negedge Clk_V);
      chk("rnd_valid", cmd_valid_o, (q.size() != 0));
      chk("rnd_full", fifo_full_o, (q.size() == DEPTH));
      if (q.size() != 0) chk("rnd_data", cmd_data_o, q[0]);
      chk("rnd_err", err_invalid_o, exp_err);
      chk("rnd_drop", drop_o, exp_drop);
      chk("rnd_cnt", invalid_cnt_o, m_cnt);
      @(posedge Clk_V);
      pop = cmd_ready_i && (q.size() != 0);
      push_ok = 1'b0;
      exp_err = 1'b0;
      exp_drop = 1'b0;
      r = 9'h000;
      if (m_pend && m_due == cyc) begin
        m_pend = 1'b0;
        r = vlookup(m_code);
        if (r[8]) begin
          exp_err = 1'b1;
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'h01;
        end else if (q.size() < DEPTH || pop) begin
          push_ok = 1'b1;
        end else begin
          exp_drop = 1'b1;
        end
      end
      if (pop) void'(q.pop_front());
      if (push_ok) q.push_back(r[7:0]);
      if (rx_done_i) begin
        b = rx_byte_i;
        if (m_mode == 1) begin
          if (b == m_last) m_last = 8'h00;
          m_mode = 0;
        end else if (m_mode == 2) begin
          m_mode = (b == 8'hF0) ? 1 : 0;
        end else if (b == 8'hF0) begin
          m_mode = 1;
        end else if (b == 8'hE0) begin
          m_mode = 2;
        end else if (b != m_last) begin
          m_last = b;
          m_pend = 1'b1;
          m_code = b;
          m_due = cyc + 2;
        end
      end
      cyc++;
      #1;
    end
    rx_done_i = 1'b0;
    cmd_ready_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kb_cmd_sequencer.md
Name: kb_cmd_sequencer

Overview:
Sequences raw PS/2 scan-code bytes into the keycode validator and queues the accepted ASCII commands for the downstream control FSM.
- Strips break (F0) and extended (E0) prefixes and suppresses typematic repeats.
- Holds each make code on the validator input long enough for its registered enable to settle, then samples the result.
- Pushes valid ASCII into a small FIFO with a ready/valid output; counts rejected keys.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2)
TIMEOUT_CYC, 1024, cycles allowed between a prefix byte (F0/E0) and its following byte
CNT_W, 8, width of the saturating invalid-key counter

Ports:
Clk_V  input  1  system clock
Reset_V  input  1  asynchronous, active-high reset
rx_byte_i  input  8  byte from the PS/2 receiver
rx_done_i  input  1  one-cycle strobe, rx_byte_i valid
val_keycode_o  output  8  scan code driven to the validator keycode input
val_ascii_i  input  8  validator ASCII output
val_invalid_i  input  1  validator invalid flag (1 = reject)
cmd_data_o  output  8  FIFO head ASCII
cmd_valid_o  output  1  FIFO non-empty
cmd_ready_i  input  1  consumer accepts head when cmd_valid_o & cmd_ready_i
fifo_full_o  output  1  FIFO holds FIFO_DEPTH entries
err_invalid_o  output  1  one-cycle pulse per rejected key
drop_o  output  1  one-cycle pulse when a valid key is lost to a full FIFO
invalid_cnt_o  output  CNT_W  saturating count of rejected keys

Behaviour:
Reset values:
- All outputs 0; FIFO empty; last_make = 00; FSM = IDLE.

FSM states: IDLE, BRK, EXT, LATCH, CHECK.
- IDLE, rx_done_i with byte F0 -> BRK; byte E0 -> EXT.
- IDLE, other byte equal to last_make -> stays in IDLE, no action (typematic repeat).
- IDLE, other byte -> code_r <= byte, last_make <= byte, go to LATCH.
- EXT, next byte F0 -> BRK; any other byte -> IDLE. Extended keys are not forwarded.
- BRK, next byte B: if B == last_make, last_make <= 00. Go to IDLE, no push.
- BRK/EXT: timer counts from prefix; reaching TIMEOUT_CYC-1 with no byte -> IDLE, timer cleared.
- LATCH (1 cycle): val_keycode_o = code_r, so the validator's registered enable updates. Go to CHECK.
- CHECK (1 cycle): val_keycode_o = code_r; sample val_invalid_i / val_ascii_i.
  - Invalid: err_invalid_o pulse next cycle; invalid_cnt_o += 1, saturating at all-ones.
  - Valid and FIFO not full: push val_ascii_i.
  - Valid and FIFO full: drop_o pulse; no overwrite.
  - Then go to IDLE.
- val_keycode_o = code_r at all times (holds last code); code_r resets to 00.
- rx_done_i during LATCH/CHECK is ignored. PS/2 byte spacing makes this unreachable in practice; it is defined anyway.
- Latency: rx_done_i edge to cmd_valid_o rising (empty FIFO) = 3 cycles (LATCH, CHECK, write).

FIFO:
- Circular buffer, log2(FIFO_DEPTH)+1-bit pointers; pointers wrap modulo 2·DEPTH.
- Full when the MSBs differ and the rest are equal.
- Simultaneous push and pop: permitted in all occupancy states including full. Pop frees the slot in the same cycle, so a push while full-and-popping succeeds and count is unchanged.
- cmd_data_o = mem[rd_ptr]; it is stable while cmd_valid_o & ~cmd_ready_i.

Reset mid-operation:
- Asynchronous clear of FSM, FIFO pointers, counter, last_make and timer.
- Pending pulses are cancelled.

Decomposition:
- Package kb_pkg: state enum; constants KC_BREAK = 8'hF0, KC_EXT = 8'hE0.
- One sub-module: kb_cmd_fifo (parameterised sync FIFO with push/pop/full/empty), instantiated once.
- The validator is instantiated beside this block at top level, not inside it.

Test Plan:
- Byte 16 then F0,16 with the validator returning 31/valid -> one push of 31; cmd_valid_o rises 3 cycles after the first strobe; last_make back to 00.
- Byte 16 repeated 3 times, then F0,16, then 16 -> exactly two 31 entries (repeat suppressed, re-press accepted).
- Byte 1A with val_invalid_i=1 -> err_invalid_o pulse, invalid_cnt_o = 1, no push; 256 more invalid keys with CNT_W=8 -> counter holds FF.
- Five distinct valid keys (16,1E,26,25,2E), cmd_ready_i=0, DEPTH=4 -> fifo_full_o=1, drop_o pulses once, FIFO drains 31,32,33,34.
- F0 then no byte for TIMEOUT_CYC cycles -> FSM back in IDLE; next 1E produces 32.
- Reset_V asserted in the CHECK cycle with cmd_ready_i=1 and simultaneous push/pop at full -> all outputs 0 immediately, nothing pushed.
